// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master to one-slave IO bus arbiter
//
// Purpose: grants one of two masters (m0, m1) access to a single IO slave.
// Ties are broken in favour of the master not served last. The granted
// request is latched and presented to the slave until s_ready; the owner
// then receives a one-cycle ack with the registered read data.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   m0_*/m1_* (inputs)       req, we, addr[31:0], wdata[31:0] per master
//   m0_*/m1_* (outputs)      rdata[31:0], ack, err per master
//   s_addr, s_wdata          slave address / write data (addr all-ones when idle)
//   s_rd_e, s_wr_e           slave read / write strobes
//   s_rdata, s_ready         slave read data / completion
//   grant_o[1:0]             one-hot owner (bit0 = m0, bit1 = m1)
//
// Parameter TIMEOUT_CYC: ACCESS cycles without s_ready before abort (1..65535).
// Macro IO_ARB_TIMEOUT_EN: enables the ACCESS timeout counter and m*_err.

module io_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_rd_e,
    output logic        s_wr_e,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state_q;
    logic   owner_q;       // 0 = m0, 1 = m1
    logic   we_q;
    logic   last_owner_q;  // master served most recently, 1 = m1
    logic   pick_m1_d;

    generate
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
            $error("io_bus_arbiter: TIMEOUT_CYC out of range 1..65535");
        end
    endgenerate

    // m1 wins when it is the only requester, or on a tie when m0 was served last.
    always_comb begin
        pick_m1_d = m1_req && (!m0_req || !last_owner_q);
    end

`ifdef IO_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q;
    logic [1:0]  err_q;
    assign m0_err = err_q[0];
    assign m1_err = err_q[1];
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            last_owner_q <= 1'b1;
            grant_o      <= 2'b00;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= 32'h0;
            m1_rdata     <= 32'h0;
            s_addr       <= 32'hFFFF_FFFF;
            s_wdata      <= 32'h0;
            s_rd_e       <= 1'b0;
            s_wr_e       <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
            cnt_q        <= 16'h0;
            err_q        <= 2'b00;
`endif
        end else begin
            // ack/err are single-cycle pulses; set only on entry to RESP.
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
            err_q  <= 2'b00;
`endif
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner_q <= pick_m1_d;
                        we_q    <= pick_m1_d ? m1_we : m0_we;
                        s_addr  <= pick_m1_d ? m1_addr : m0_addr;
                        s_wdata <= pick_m1_d ? m1_wdata : m0_wdata;
                        s_rd_e  <= pick_m1_d ? !m1_we : !m0_we;
                        s_wr_e  <= pick_m1_d ? m1_we : m0_we;
                        grant_o <= pick_m1_d ? 2'b10 : 2'b01;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (s_ready) begin
                        s_rd_e <= 1'b0;
                        s_wr_e <= 1'b0;
                        if (!we_q) begin
                            if (owner_q) m1_rdata <= s_rdata;
                            else         m0_rdata <= s_rdata;
                        end
                        m0_ack  <= !owner_q;
                        m1_ack  <= owner_q;
                        state_q <= RESP;
`ifdef IO_ARB_TIMEOUT_EN
                        cnt_q   <= 16'h0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        // Abort: owner sees all-ones data with err alongside ack.
                        s_rd_e  <= 1'b0;
                        s_wr_e  <= 1'b0;
                        if (owner_q) m1_rdata <= 32'hFFFF_FFFF;
                        else         m0_rdata <= 32'hFFFF_FFFF;
                        m0_ack  <= !owner_q;
                        m1_ack  <= owner_q;
                        err_q   <= owner_q ? 2'b10 : 2'b01;
                        cnt_q   <= 16'h0;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= cnt_q + 16'h1;
`endif
                    end
                end
                RESP: begin
                    // Requests are not arbitrated here; at least one IDLE cycle follows.
                    last_owner_q <= owner_q;
                    grant_o      <= 2'b00;
                    s_addr       <= 32'hFFFF_FFFF;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - self-checking bench for io_bus_arbiter
module tb_io_bus_arbiter;

    localparam int TO = 4;
`ifdef IO_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_rd_e, s_wr_e, s_ready;
    logic [1:0]  grant_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference state
    logic [31:0] exp_rd [2];
    int          last_m;

    always #5 clk = ~clk;

    io_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rd_e(s_rd_e), .s_wr_e(s_wr_e),
        .s_rdata(s_rdata), .s_ready(s_ready), .grant_o(grant_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/grant"}, 32'(grant_o), 32'h0);
        check({tag, "/acks"}, {30'h0, m1_ack, m0_ack}, 32'h0);
        check({tag, "/errs"}, {30'h0, m1_err, m0_err}, 32'h0);
        check({tag, "/strobes"}, {30'h0, s_wr_e, s_rd_e}, 32'h0);
        check({tag, "/m0_rdata"}, m0_rdata, 32'h0);
        check({tag, "/m1_rdata"}, m1_rdata, 32'h0);
        check({tag, "/s_addr"}, s_addr, 32'hFFFF_FFFF);
        check({tag, "/s_wdata"}, s_wdata, 32'h0);
    endtask

    // Arbitration rule: sole requester wins; on a tie the master not served last.
    function automatic logic [1:0] pick(input logic r0, input logic r1);
        if (r0 && r1) return (last_m == 1) ? 2'b01 : 2'b10;
        return r0 ? 2'b01 : 2'b10;
    endfunction

    // Drives one transaction from IDLE and plays the slave; expectations come
    // from exp_g and the reference state. Returns with the DUT back in IDLE.
    task automatic run_txn(input logic r0, input logic r1, input logic w0, input logic w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int delay, input logic [31:0] srd,
                           input logic [1:0] exp_g, input string tag);
        int          o;
        logic        ow_we;
        logic [31:0] ow_a, ow_d;
        bit          to_exp, done;
        int          exp_strobes, k;
        o           = exp_g[1] ? 1 : 0;
        ow_we       = o ? w1 : w0;
        ow_a        = o ? a1 : a0;
        ow_d        = o ? d1 : d0;
        to_exp      = TMO_EN && (delay + 1 > TO);
        exp_strobes = to_exp ? TO : delay + 1;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        s_ready = 1'b0;
        @(posedge clk); #1;
        check({tag, "/grant"}, 32'(grant_o), 32'(exp_g));
        // Owner changes its inputs after grant; the latched copy must be used.
        if (o == 1) begin
            m1_we = ~w1; m1_addr = $urandom; m1_wdata = $urandom;
            if ($urandom_range(0, 1) == 1) m1_req = 1'b0;
        end else begin
            m0_we = ~w0; m0_addr = $urandom; m0_wdata = $urandom;
            if ($urandom_range(0, 1) == 1) m0_req = 1'b0;
        end
        k = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (s_rd_e || s_wr_e) begin
                k++;
                check({tag, "/s_addr"}, s_addr, ow_a);
                check({tag, "/s_rd_e"}, 32'(s_rd_e), 32'(!ow_we));
                check({tag, "/s_wr_e"}, 32'(s_wr_e), 32'(ow_we));
                if (ow_we) check({tag, "/s_wdata"}, s_wdata, ow_d);
                check({tag, "/acks_in_access"}, {30'h0, m1_ack, m0_ack}, 32'h0);
                if (!to_exp && k == delay + 1) begin
                    s_ready = 1'b1; s_rdata = srd;
                end else begin
                    s_ready = 1'b0; s_rdata = $urandom;
                end
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        s_ready = 1'b0;
        check({tag, "/access_bound"}, 32'(done), 32'h1);
        check({tag, "/strobe_cycles"}, 32'(k), 32'(exp_strobes));
        if (to_exp)      exp_rd[o] = 32'hFFFF_FFFF;
        else if (!ow_we) exp_rd[o] = srd;
        check({tag, "/acks"}, {30'h0, m1_ack, m0_ack}, (o == 1) ? 32'h2 : 32'h1);
        check({tag, "/errs"}, {30'h0, m1_err, m0_err}, to_exp ? ((o == 1) ? 32'h2 : 32'h1) : 32'h0);
        check({tag, "/m0_rdata"}, m0_rdata, exp_rd[0]);
        check({tag, "/m1_rdata"}, m1_rdata, exp_rd[1]);
        last_m = o;
        if (o == 1) m1_req = 1'b0; else m0_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "/idle_acks"}, {30'h0, m1_ack, m0_ack}, 32'h0);
        check({tag, "/idle_grant"}, 32'(grant_o), 32'h0);
        check({tag, "/idle_s_addr"}, s_addr, 32'hFFFF_FFFF);
        check({tag, "/idle_strobes"}, {30'h0, s_wr_e, s_rd_e}, 32'h0);
    endtask

    typedef struct {
        logic       r0, r1, w0, w1;
        int         delay;
        logic [1:0] exp_g;
    } vec_t;

    initial begin
        vec_t        vt [8];
        logic        pend [2];
        logic        pw   [2];
        logic [31:0] pa   [2];
        logic [31:0] pd   [2];
        logic [1:0]  g;

        // Sequence from reset (last served = m1); first three rows are tied writes.
        vt[0] = '{1, 1, 1, 1, 0, 2'b01};
        vt[1] = '{1, 1, 1, 1, 0, 2'b10};
        vt[2] = '{1, 1, 1, 1, 0, 2'b01};
        vt[3] = '{0, 1, 0, 0, 1, 2'b10};
        vt[4] = '{1, 0, 0, 1, 2, 2'b01};
        vt[5] = '{1, 1, 1, 0, 0, 2'b10};
        vt[6] = '{1, 1, 0, 1, 3, 2'b01};
        vt[7] = '{0, 1, 0, 0, 1, 2'b10};

        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; last_m = 1;
        rst_i = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_rdata = 0; s_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_i = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("post_reset_idle");

        foreach (vt[i]) begin
            run_txn(vt[i].r0, vt[i].r1, vt[i].w0, vt[i].w1,
                    32'hFFFF_F100 + 32'(i), 32'hFFFF_F200 + 32'(i),
                    32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
                    vt[i].delay, 32'hC0DE_0000 + 32'(i), vt[i].exp_g,
                    $sformatf("table%0d", i));
        end

        // Single read, immediate ready: minimum latency.
        run_txn(1, 0, 0, 0, 32'hFFFF_F000, 0, 0, 0, 0, 32'h1234_5678, 2'b01, "min_read");
        check("min_read/m0_rdata_hold", m0_rdata, 32'h1234_5678);

        // Reset in the second ACCESS cycle with s_ready high: aborted, no ack.
        m0_req = 1; m0_we = 0; m0_addr = 32'hFFFF_F010;
        @(posedge clk); #1;
        check("rst_mid/grant", 32'(grant_o), 32'h1);
        @(posedge clk); #1;
        rst_i = 1'b1; s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check_reset_vals("rst_mid");
        rst_i = 1'b0; s_ready = 1'b0; m0_req = 0;
        exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; last_m = 1;
        @(posedge clk); #1;
        check("rst_mid/no_ack_after", {30'h0, m1_ack, m0_ack}, 32'h0);
        // last served was m0 before reset; reset restores the m0-first tie.
        run_txn(1, 1, 0, 1, 32'hFFFF_F020, 32'hFFFF_F024, 0, 32'h55, 0, 32'h0BAD_F00D,
                2'b01, "rst_mid_next");

        // m1 write with slow slave and address changed after grant.
        run_txn(0, 1, 0, 1, 0, 32'hFFFF_F060, 0, 32'hA5A5_A5A5, 5, 32'h0, 2'b10, "slow_write");

`ifdef IO_ARB_TIMEOUT_EN
        run_txn(1, 0, 0, 0, 32'hFFFF_F080, 0, 0, 0, 1000, 32'h0, 2'b01, "timeout");
        check("timeout/m0_rdata_hold", m0_rdata, 32'hFFFF_FFFF);
`endif

        // Randomized traffic against the transaction-level model.
        pend[0] = 0; pend[1] = 0;
        for (int it = 0; it < 40; it++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(0, 1) == 1) begin
                    pend[m] = 1; pw[m] = 1'($urandom); pa[m] = $urandom; pd[m] = $urandom;
                end
            end
            if (!pend[0] && !pend[1]) begin
                int m = $urandom_range(0, 1);
                pend[m] = 1; pw[m] = 1'($urandom); pa[m] = $urandom; pd[m] = $urandom;
            end
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    pw[m] = 1'($urandom); pa[m] = $urandom; pd[m] = $urandom;
                end
            end
            g = pick(pend[0], pend[1]);
            run_txn(pend[0], pend[1], pw[0], pw[1], pa[0], pa[1], pd[0], pd[1],
                    $urandom_range(0, 3), $urandom, g, $sformatf("rand%0d", it));
            pend[g[1] ? 1 : 0] = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
